mlp_hex_display_ctrl: RTL and testbench
=======================================

// Module: mlp_hex_display_ctrl
// PURPOSE
//  Parametrised 7-segment display controller for the DE10-Lite MLP computer.
//  Sits between a producer (PIO or MLP result path) and the HEX0..HEXn pins, replacing the raw hex3_hex0/hex5_hex4 drive.
//  Accepts one binary value per valid/ready handshake and renders it as hex or signed/unsigned decimal.
//  Decimal conversion is sequential double-dabble.
//  Optional leading-zero blanking, overflow indication, atomic display update.
// PARAMETERS
//  N_DIGITS    6   number of 7-seg digits driven (1..8)
//  DATA_W      16  input value width (4..32)
//  ACTIVE_LOW  1   1: hex_out inverted at output (DE10-Lite pins); 0: segment on = 1
// PORTS
//  clk        in   1            system clock
//  reset      in   1            synchronous, active-high reset
//  in_valid   in   1            producer has a value
//  in_ready   out  1            controller can accept (IDLE only)
//  in_data    in   DATA_W       value to display
//  in_mode    in   1            0 = hex, 1 = decimal; sampled at accept
//  in_signed  in   1            decimal only: treat in_data as two's complement; sampled at accept
//  in_blank   in   1            1 = blank leading zeros; sampled at accept
//  hex_out    out  8*N_DIGITS   digit k on [8k+7:8k]; bit0=a..bit6=g, bit7=DP (always off)
//  overflow   out  1            last value did not fit in N_DIGITS
//  busy       out  1            conversion in progress (= ~in_ready)
// BEHAVIOUR
//  Reset: in_ready=1, busy=0, overflow=0, all segments off (hex_out all 1s if ACTIVE_LOW, else 0). FSM->IDLE.
//  Reset mid-operation aborts conversion; the in-flight value is discarded.
//  Encoding (active-high): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F,
//                          A 77, b 7C, C 39, d 5E, E 79, F 71, '-' 40, blank 00.
//  Handshake: transfer when in_valid && in_ready. in_ready=1 only in IDLE.
//  in_data/in_mode/in_signed/in_blank are registered on transfer; later changes are ignored.
//  FSM: IDLE -(transfer)-> CONVERT -(done)-> LATCH -> IDLE.
//  - CONVERT, hex: 1 cycle. Nibbles taken directly from the raw value; in_signed is ignored.
//  - CONVERT, decimal: exactly DATA_W cycles, one shift-add-3 step per cycle.
//    Signed negative input: convert magnitude (DATA_W-bit unsigned, so -2^(DATA_W-1) is exact).
//    Internal BCD register covers the full DATA_W range (ceil(DATA_W/3)+1 digits).
//  - LATCH: compose the digit vector; hex_out, overflow update together on the edge ending LATCH.
//  Latency: transfer in cycle T -> new hex_out visible in cycle T+3 (hex) or T+DATA_W+2 (decimal).
//    in_ready returns high in that same cycle.
//  hex_out holds its previous value for the whole conversion: no partial or flicker states.
//  Sign: the '-' occupies one digit and is placed immediately left of the most significant shown digit.
//    If in_blank=0, that is digit N_DIGITS-1 instead.
//  Blanking: digits above the most significant nonzero digit are blank; digit 0 is always shown (value 0 -> "0").
//  Overflow: the required digits (incl. '-') exceed N_DIGITS, or in hex mode nonzero bits above 4*N_DIGITS.
//    Then every digit shows '-' and overflow=1.
//    overflow clears on the next LATCH of a value that fits.
//  in_valid held high continuously: one transfer per completed conversion, no transfer lost or duplicated.
// TESTING
//  1 Release reset, ACTIVE_LOW=1, N=6 -> hex_out=48'hFFFF_FFFF_FFFF, in_ready=1, overflow=0, busy=0.
//  2 Decimal unsigned 16'd1234, blank=1 -> dig3..0 = 06,5B,4F,66; dig5,4 = 00; update exactly 18 cycles after transfer.
//  3 Decimal signed 16'hFFFF (-1), blank=1 -> dig0=06, dig1=40, dig5..2=00.
//    Decimal signed 16'h8000 -> "-32768": dig5=40, dig4..0 = 4F,5B,07,7D,7F.
//  4 N_DIGITS=4, decimal unsigned 16'd65535 -> overflow=1, all digits 40.
//    Next value 16'd7 -> overflow=0, dig0=07, dig3..1=00.
//  5 Hex 16'hBEEF, blank=0, N=6 -> dig5..0 = 3F,3F,7C,79,79,71; in_ready low for 2 cycles; update at T+3.
//  6 Decimal 16'd500 in flight, reset at cycle T+5 -> segments off, in_ready=1 next cycle.
//    Then transfer 16'd42 -> dig1,0 = 66,5B. in_valid held high throughout: single transfer per conversion.

Source files
------------

// File: rtl/mlp_hex_display_ctrl.sv
// 7-segment display controller: accepts one value per valid/ready handshake and renders it as
// hex or signed/unsigned decimal (sequential double-dabble), updating all digits atomically.
module mlp_hex_display_ctrl #(
  parameter int N_DIGITS   = 6,
  parameter int DATA_W     = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_mode,
  input  logic                  in_signed,
  input  logic                  in_blank,
  output logic [8*N_DIGITS-1:0] hex_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam int BCD_D = (DATA_W + 2) / 3 + 1;
  localparam int BCD_W = 4 * BCD_D;
  localparam int SRC_D = (BCD_D > N_DIGITS) ? BCD_D : N_DIGITS;
  localparam int EXT_W = 4 * SRC_D;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = 5;
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_LATCH   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       mag_q, mag_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic                    neg_q, neg_d;
  logic                    blank_q, blank_d;
  logic [8*N_DIGITS-1:0]   hex_q, hex_d;
  logic                    ovf_q, ovf_d;
  logic                    ready_q;

  logic [EXT_W-1:0]        bcd_ext_s;
  logic [IDX_W-1:0]        msd_s;
  logic [IDX_W-1:0]        nreq_s;
  logic [IDX_W-1:0]        sign_pos_s;
  logic                    ovf_s;
  logic [6:0]              seg_s;
  logic [8*N_DIGITS-1:0]   disp_s;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'h3F;
      4'h1:    seg7 = 7'h06;
      4'h2:    seg7 = 7'h5B;
      4'h3:    seg7 = 7'h4F;
      4'h4:    seg7 = 7'h66;
      4'h5:    seg7 = 7'h6D;
      4'h6:    seg7 = 7'h7D;
      4'h7:    seg7 = 7'h07;
      4'h8:    seg7 = 7'h7F;
      4'h9:    seg7 = 7'h6F;
      4'hA:    seg7 = 7'h77;
      4'hB:    seg7 = 7'h7C;
      4'hC:    seg7 = 7'h39;
      4'hD:    seg7 = 7'h5E;
      4'hE:    seg7 = 7'h79;
      4'hF:    seg7 = 7'h71;
      default: seg7 = 7'h40;
    endcase
  endfunction

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic in_bit);
    logic [BCD_W-1:0] t;
    t = b;
    for (int i = 0; i < BCD_D; i++) begin
      if (t[4*i +: 4] >= 4'd5) begin
        t[4*i +: 4] = t[4*i +: 4] + 4'd3;
      end else begin
        t[4*i +: 4] = t[4*i +: 4];
      end
    end
    dd_step = {t[BCD_W-2:0], in_bit};
  endfunction

  // State register and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      neg_q   <= 1'b0;
      blank_q <= 1'b0;
      hex_q   <= {N_DIGITS{SEG_OFF}};
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      neg_q   <= neg_d;
      blank_q <= blank_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
      ready_q <= (state_d == S_IDLE);
    end
  end

  // Next-state logic: capture on transfer, convert, then publish the composed display.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    neg_d   = neg_q;
    blank_d = blank_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CONVERT;
          mode_d  = in_mode;
          blank_d = in_blank;
          neg_d   = in_mode & in_signed & in_data[DATA_W-1];
          // The negated MSB-only value wraps to itself, which is its correct unsigned magnitude.
          if (in_mode & in_signed & in_data[DATA_W-1]) begin
            mag_d = (~in_data) + {{(DATA_W-1){1'b0}}, 1'b1};
          end else begin
            mag_d = in_data;
          end
          bcd_d = '0;
          cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONVERT: begin
        if (!mode_q) begin
          bcd_d   = BCD_W'(mag_q);
          state_d = S_LATCH;
        end else begin
          bcd_d = dd_step(bcd_q, mag_q[DATA_W-1]);
          mag_d = mag_q << 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_CONVERT;
          end
        end
      end
      S_LATCH: begin
        hex_d   = disp_s;
        ovf_d   = ovf_s;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Display composition from the finished digit register: blanking, sign placement, overflow.
  always_comb begin
    bcd_ext_s = EXT_W'(bcd_q);
    msd_s     = '0;
    seg_s     = 7'h00;
    disp_s    = '0;
    for (int k = 0; k < BCD_D; k++) begin
      if (bcd_ext_s[4*k +: 4] != 4'd0) begin
        msd_s = IDX_W'(k);
      end else begin
        msd_s = msd_s;
      end
    end
    // In hex mode any nonzero nibble at or above N_DIGITS pushes the digit count past the limit.
    nreq_s = msd_s + 5'd1 + {{(IDX_W-1){1'b0}}, neg_q};
    ovf_s  = (nreq_s > IDX_W'(N_DIGITS));
    if (blank_q) begin
      sign_pos_s = msd_s + 5'd1;
    end else begin
      sign_pos_s = IDX_W'(N_DIGITS - 1);
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      if (ovf_s) begin
        seg_s = 7'h40;
      end else if (IDX_W'(k) <= msd_s) begin
        seg_s = seg7(bcd_ext_s[4*k +: 4]);
      end else if (neg_q && (IDX_W'(k) == sign_pos_s)) begin
        seg_s = 7'h40;
      end else if (blank_q) begin
        seg_s = 7'h00;
      end else begin
        seg_s = 7'h3F;
      end
      disp_s[8*k +: 8] = SEG_OFF ^ {1'b0, seg_s};
    end
  end

  assign in_ready = ready_q;
  assign busy     = ~ready_q;
  assign hex_out  = hex_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mlp_hex_display_ctrl.sv
// Self-checking bench: two controllers (6 and 4 digits) share stimulus and are compared
// against a digit-string reference model built from plain integer arithmetic.
module tb_mlp_hex_display_ctrl;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_mode;
  logic        in_signed;
  logic        in_blank;
  logic        rdy6, rdy4;
  logic [47:0] hex6;
  logic [31:0] hex4;
  logic        ovf6, ovf4;
  logic        busy6, busy4;

  int          n_checks;
  int          n_fail;
  logic [63:0] e6, e4;
  logic        eo6, eo4;
  int          exp_lat;
  logic [47:0] prev6;
  logic [31:0] prev4;
  logic        prevo6, prevo4;
  logic [15:0] rv;

  mlp_hex_display_ctrl #(.N_DIGITS(6), .DATA_W(16), .ACTIVE_LOW(1'b1)) dut6 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy6), .in_data(in_data),
    .in_mode(in_mode), .in_signed(in_signed), .in_blank(in_blank), .hex_out(hex6),
    .overflow(ovf6), .busy(busy6)
  );

  mlp_hex_display_ctrl #(.N_DIGITS(4), .DATA_W(16), .ACTIVE_LOW(1'b1)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
    .in_mode(in_mode), .in_signed(in_signed), .in_blank(in_blank), .hex_out(hex4),
    .overflow(ovf4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: split the magnitude into base-10/16 digits, then apply sign/blank/overflow rules.
  function automatic void model(input logic [15:0] v, input bit m, input bit s, input bit b,
                                input int n, output logic [63:0] exp_hex, output logic exp_ovf);
    int mag, base, ndig, sign_pos;
    bit neg;
    int d[8];
    logic [6:0] seg;
    neg  = m && s && v[15];
    mag  = neg ? (65536 - int'(v)) : int'(v);
    base = m ? 10 : 16;
    ndig = 1;
    for (int i = 0; i < 8; i++) begin
      d[i] = mag % base;
      mag  = mag / base;
      if (d[i] != 0) ndig = i + 1;
    end
    exp_ovf  = ((ndig + int'(neg)) > n);
    sign_pos = b ? ndig : n - 1;
    exp_hex  = '0;
    for (int k = 0; k < n; k++) begin
      if (exp_ovf) seg = 7'h40;
      else if (k < ndig) seg = SEG_TAB[d[k]];
      else if (neg && k == sign_pos) seg = 7'h40;
      else if (b) seg = 7'h00;
      else seg = 7'h3F;
      exp_hex[8*k +: 8] = ~{1'b0, seg};
    end
  endfunction

  task automatic start_txn(input logic [15:0] v, input bit m, input bit s, input bit b);
    in_data   = v;
    in_mode   = m;
    in_signed = s;
    in_blank  = b;
    in_valid  = 1'b1;
    model(v, m, s, b, 6, e6, eo6);
    model(v, m, s, b, 4, e4, eo4);
    exp_lat = m ? 18 : 3;
    prev6   = hex6;
    prev4   = hex4;
    prevo6  = ovf6;
    prevo4  = ovf4;
    @(posedge clk);
  endtask

  task automatic finish_txn();
    int lat;
    bit held;
    lat  = 0;
    held = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rdy6) break;
      if (hex6 !== prev6 || hex4 !== prev4 || ovf6 !== prevo6 || ovf4 !== prevo4) held = 1'b0;
      if (busy6 !== 1'b1 || busy4 !== 1'b1 || rdy4 !== 1'b0) held = 1'b0;
      in_data   = 16'($urandom);
      in_mode   = 1'($urandom);
      in_signed = 1'($urandom);
      in_blank  = 1'($urandom);
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("hold", 64'(held), 64'(1));
    check_eq("hex6", 64'(hex6), e6);
    check_eq("ovf6", 64'(ovf6), 64'(eo6));
    check_eq("hex4", 64'(hex4), e4);
    check_eq("ovf4", 64'(ovf4), 64'(eo4));
    check_eq("busy_done", 64'({busy6, busy4, rdy4}), 64'(3'b001));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    in_mode   = 1'b0;
    in_signed = 1'b0;
    in_blank  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_hex6", 64'(hex6), 64'(48'hFFFF_FFFF_FFFF));
    check_eq("reset_hex4", 64'(hex4), 64'(32'hFFFF_FFFF));
    check_eq("reset_flags", 64'({rdy6, ovf6, busy6, ovf4}), 64'(4'b1000));

    start_txn(16'd1234, 1'b1, 1'b0, 1'b1);
    finish_txn();
    check_eq("dec1234_const", 64'(hex6), 64'(48'hFFFF_F9A4_B099));
    start_txn(16'hFFFF, 1'b1, 1'b1, 1'b1);
    finish_txn();
    start_txn(16'h8000, 1'b1, 1'b1, 1'b1);
    finish_txn();
    start_txn(16'd65535, 1'b1, 1'b0, 1'b1);
    finish_txn();
    check_eq("ovf4_set", 64'(ovf4), 64'(1));
    start_txn(16'd7, 1'b1, 1'b0, 1'b1);
    finish_txn();
    check_eq("ovf4_clear", 64'(ovf4), 64'(0));
    start_txn(16'hBEEF, 1'b0, 1'b1, 1'b0);
    finish_txn();
    start_txn(16'h8000, 1'b1, 1'b1, 1'b0);
    finish_txn();

    // Abort a decimal conversion with reset in cycle T+5, keeping in_valid high.
    start_txn(16'd500, 1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_hex6", 64'(hex6), 64'(48'hFFFF_FFFF_FFFF));
    check_eq("abort_flags", 64'({rdy6, busy6, ovf6, rdy4}), 64'(4'b1001));
    reset = 1'b0;
    start_txn(16'd42, 1'b1, 1'b0, 1'b1);
    finish_txn();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        prev6    = hex6;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check_eq("idle", 64'({rdy6, hex6}), 64'({1'b1, prev6}));
      end
      if ($urandom_range(0, 3) == 0) rv = 16'($urandom_range(0, 15));
      else rv = 16'($urandom);
      start_txn(rv, 1'($urandom), 1'($urandom), 1'($urandom));
      finish_txn();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
